// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler
//   Redraws the 10-slot note lane once per frame_tick. The red/yellow note
//   sequences are snapshotted on the accepted tick, then slots are walked in
//   order; each slot whose colour differs from what was last drawn there is
//   painted as a 4x4 square of pixels streamed to the VGA adapter. A done
//   pulse tells the game logic the note shifters may advance.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle redraw request (ignored and flagged while busy)
//   red_seq     bit i set = red note in slot i (red wins over yellow)
//   yellow_seq  bit i set = yellow note in slot i
//   x, y        registered pixel coordinates
//   colour      registered pixel colour (BLACK 000, RED 100, YELLOW 110)
//   plot        registered pixel write enable
//   busy        high while a frame redraw is in progress
//   done        one-cycle pulse when a frame redraw completes
//   overrun     sticky flag: a frame_tick arrived while busy
module note_lane_scheduler #(
    parameter int NUM_SLOTS  = 10,
    parameter int X_BASE     = 10,
    parameter int SLOT_PITCH = 10,
    parameter int Y_BASE     = 112
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [NUM_SLOTS-1:0] red_seq,
    input  logic [NUM_SLOTS-1:0] yellow_seq,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam logic [2:0] BLACK     = 3'b000;
    localparam logic [2:0] RED       = 3'b100;
    localparam logic [2:0] YELLOW    = 3'b110;
    localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DRAW,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           slot_q, slot_d;
    logic [3:0]           pix_q, pix_d;
    logic [NUM_SLOTS-1:0] red_snap_q, red_snap_d;
    logic [NUM_SLOTS-1:0] yellow_snap_q, yellow_snap_d;
    logic [2:0]           lat_colour_q, lat_colour_d;
    logic                 first_frame_q, first_frame_d;
    logic [2:0]           prev_colour_q [NUM_SLOTS];
    logic [2:0]           prev_colour_d [NUM_SLOTS];

    logic [7:0]           x_q, x_d;
    logic [6:0]           y_q, y_d;
    logic [2:0]           colour_q, colour_d;
    logic                 plot_q, plot_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;

    logic [2:0]           slot_colour;
    logic [7:0]           x_calc;
    logic [6:0]           y_calc;

    // Colour of the slot currently being evaluated, from the snapshot.
    always_comb begin
        slot_colour = BLACK;
        if (red_snap_q[slot_q]) begin
            slot_colour = RED;
        end else if (yellow_snap_q[slot_q]) begin
            slot_colour = YELLOW;
        end
    end

    // Pixel address inside the square; x wraps modulo 256 by construction.
    assign x_calc = 8'(X_BASE) + 8'(slot_q) * 8'(SLOT_PITCH) + {6'd0, pix_q[1:0]};
    assign y_calc = 7'(Y_BASE) + {5'd0, pix_q[3:2]};

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        pix_d         = pix_q;
        red_snap_d    = red_snap_q;
        yellow_snap_d = yellow_snap_q;
        lat_colour_d  = lat_colour_q;
        first_frame_d = first_frame_q;
        prev_colour_d = prev_colour_q;
        x_d           = x_q;
        y_d           = y_q;
        colour_d      = colour_q;

        // Output registers trail the state register by one cycle.
        plot_d    = (state_q == S_DRAW);
        done_d    = (state_q == S_DONE);
        overrun_d = overrun_q | (frame_tick & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    red_snap_d    = red_seq;
                    yellow_snap_d = yellow_seq;
                    slot_d        = 4'd0;
                    state_d       = S_EVAL;
                end
            end
            S_EVAL: begin
                if (first_frame_q || (slot_colour != prev_colour_q[slot_q])) begin
                    lat_colour_d = slot_colour;
                    pix_d        = 4'd0;
                    state_d      = S_DRAW;
                end else if (slot_q == LAST_SLOT) begin
                    state_d = S_DONE;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            S_DRAW: begin
                x_d      = x_calc;
                y_d      = y_calc;
                colour_d = lat_colour_q;
                pix_d    = pix_q + 4'd1;
                if (pix_q == 4'd15) begin
                    // Remember what is now on screen so the next frame can skip it.
                    prev_colour_d[slot_q] = lat_colour_q;
                    if (slot_q == LAST_SLOT) begin
                        state_d = S_DONE;
                    end else begin
                        slot_d  = slot_q + 4'd1;
                        state_d = S_EVAL;
                    end
                end
            end
            S_DONE: begin
                first_frame_d = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            slot_q        <= 4'd0;
            pix_q         <= 4'd0;
            red_snap_q    <= '0;
            yellow_snap_q <= '0;
            lat_colour_q  <= BLACK;
            first_frame_q <= 1'b1;
            x_q           <= 8'd0;
            y_q           <= 7'd0;
            colour_q      <= BLACK;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            pix_q         <= pix_d;
            red_snap_q    <= red_snap_d;
            yellow_snap_q <= yellow_snap_d;
            lat_colour_q  <= lat_colour_d;
            first_frame_q <= first_frame_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    // Per-slot record of the colour currently displayed.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_prev
            always_ff @(posedge clk) begin
                if (reset) begin
                    prev_colour_q[gi] <= BLACK;
                end else begin
                    prev_colour_q[gi] <= prev_colour_d[gi];
                end
            end
        end
    endgenerate

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_note_lane_scheduler.sv
module tb_note_lane_scheduler;

    localparam int NS = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic [NS-1:0] red_seq = '0;
    logic [NS-1:0] yellow_seq = '0;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    colour;
    logic          plot;
    logic          busy;
    logic          done;
    logic          overrun;

    note_lane_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .red_seq    (red_seq),
        .yellow_seq (yellow_seq),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    // Model: expected pixel stream, what each slot shows, frame timing.
    pix_t       exp_q[$];
    logic [2:0] m_prev [NS];
    bit         m_first;
    bit         m_active;
    int         m_tick;
    int         m_done;
    bit         m_overrun;
    int         m_ov_cyc;

    int   tests = 0;
    int   fails = 0;
    int   total_plots = 0;
    int   plots_base = 0;
    bit   done_flag = 0;
    int   done_seen_cyc = 0;
    pix_t first_px;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] slot_col(input logic [NS-1:0] r, input logic [NS-1:0] yv, input int i);
        if (r[i]) return 3'b100;
        if (yv[i]) return 3'b110;
        return 3'b000;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_first   = 1;
        m_active  = 0;
        m_overrun = 0;
        for (int i = 0; i < NS; i++) m_prev[i] = 3'b000;
    endtask

    // Tick is sampled on the next rising edge (cyc+1).
    task automatic model_accept(input logic [NS-1:0] r, input logic [NS-1:0] yv);
        int   cost;
        pix_t p;
        cost = 0;
        for (int i = 0; i < NS; i++) begin
            logic [2:0] c;
            c = slot_col(r, yv, i);
            if (m_first || c != m_prev[i]) begin
                for (int k = 0; k < 16; k++) begin
                    p.px = 8'(10 + i * 10 + (k % 4));
                    p.py = 7'(112 + (k / 4));
                    p.pc = c;
                    exp_q.push_back(p);
                end
                m_prev[i] = c;
                cost += 17;
            end else begin
                cost += 1;
            end
        end
        m_first  = 0;
        m_active = 1;
        m_tick   = cyc + 1;
        m_done   = m_tick + cost + 1;
    endtask

    // Per-cycle comparison against the model.
    task automatic compare_cycle();
        pix_t e;
        check("busy", busy, m_active && cyc >= m_tick && cyc < m_done);
        check("overrun", overrun, m_overrun && cyc >= m_ov_cyc);
        check("done", done, m_active && cyc == m_done);
        if (plot) begin
            if (exp_q.size() == 0) begin
                check("unexpected_plot", plot, 0);
            end else begin
                e = exp_q.pop_front();
                check("pix_x", x, e.px);
                check("pix_y", y, e.py);
                check("pix_colour", colour, e.pc);
                if (total_plots == plots_base) begin
                    first_px.px = x;
                    first_px.py = y;
                    first_px.pc = colour;
                end
                total_plots++;
            end
        end
        if (done) begin
            check("pixels_left_at_done", exp_q.size(), 0);
            done_flag     = 1;
            done_seen_cyc = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic issue_tick(input logic [NS-1:0] r, input logic [NS-1:0] yv);
        red_seq    = r;
        yellow_seq = yv;
        frame_tick = 1;
        model_accept(r, yv);
        plots_base = total_plots;
        done_flag  = 0;
        step();
        frame_tick = 0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done_flag && n < budget) begin
            step();
            n++;
        end
        if (!done_flag) check("done_timeout", 0, 1);
    endtask

    initial begin
        model_reset();
        step();
        step();
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        reset = 0;
        step();
        step();

        // Frame 1: first frame, full redraw, slot 0 red.
        issue_tick(10'h001, 10'h000);
        wait_done(400);
        $display("[TB] frame1 latency=%0d plots=%0d", done_seen_cyc - m_tick, total_plots - plots_base);
        check("f1_latency", done_seen_cyc - m_tick, 171);
        check("f1_plots", total_plots - plots_base, 160);
        check("f1_first_x", first_px.px, 10);
        check("f1_first_y", first_px.py, 112);
        check("f1_first_colour", first_px.pc, 3'b100);

        // Frame 2: issued in the done-pulse cycle, identical sequences -> all skip.
        issue_tick(10'h001, 10'h000);
        wait_done(100);
        $display("[TB] frame2 latency=%0d plots=%0d", done_seen_cyc - m_tick, total_plots - plots_base);
        check("f2_latency", done_seen_cyc - m_tick, 11);
        check("f2_plots", total_plots - plots_base, 0);

        // Frame 3: slot 0 yellow (red cleared), slot 9 red.
        repeat (3) step();
        issue_tick(10'h200, 10'h201);
        wait_done(200);
        $display("[TB] frame3 latency=%0d plots=%0d", done_seen_cyc - m_tick, total_plots - plots_base);
        check("f3_latency", done_seen_cyc - m_tick, 43);
        check("f3_plots", total_plots - plots_base, 32);
        check("f3_first_colour", first_px.pc, 3'b110);
        check("f3_first_x", first_px.px, 10);

        // Frame 4: full redraw with an overlapping tick 50 cycles in.
        repeat (2) step();
        issue_tick(10'h1FF, 10'h200);
        repeat (49) step();
        frame_tick = 1;
        m_overrun  = 1;
        m_ov_cyc   = cyc + 1;
        step();
        frame_tick = 0;
        wait_done(400);
        $display("[TB] frame4 latency=%0d plots=%0d overrun=%0b", done_seen_cyc - m_tick, total_plots - plots_base, overrun);
        check("f4_latency", done_seen_cyc - m_tick, 171);
        check("f4_plots", total_plots - plots_base, 160);
        check("f4_overrun", overrun, 1);

        // Frame 5: unchanged -> all skip, overrun still sticky.
        repeat (2) step();
        issue_tick(10'h1FF, 10'h200);
        wait_done(100);
        $display("[TB] frame5 latency=%0d overrun=%0b", done_seen_cyc - m_tick, overrun);
        check("f5_latency", done_seen_cyc - m_tick, 11);
        check("f5_overrun", overrun, 1);

        // Frame 6: reset in the middle of slot 4's square.
        repeat (2) step();
        issue_tick(10'h000, 10'h000);
        while (cyc < m_tick + 75) step();
        reset = 1;
        model_reset();
        step();
        reset = 0;
        $display("[TB] midframe reset plot=%0b busy=%0b overrun=%0b", plot, busy, overrun);
        check("mrst_plot", plot, 0);
        check("mrst_busy", busy, 0);
        check("mrst_overrun", overrun, 0);
        repeat (3) step();

        // Frame 7: same sequences, but first frame after reset -> full redraw.
        issue_tick(10'h000, 10'h000);
        wait_done(400);
        $display("[TB] frame7 latency=%0d plots=%0d", done_seen_cyc - m_tick, total_plots - plots_base);
        check("f7_latency", done_seen_cyc - m_tick, 171);
        check("f7_plots", total_plots - plots_base, 160);
        check("f7_first_colour", first_px.pc, 3'b000);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
